// File: rtl/udp_rx_mux.sv
// rtl/udp_rx_mux.sv - UDP header parser and destination-port demultiplexer
//
// Parses the UDP header at the start of an IP payload byte stream. It compares
// the destination port against a small table of listening ports. When an entry
// matches, it forwards the UDP payload tagged with the index of that entry.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cfg_we/idx/port/en  port table write (entry index, port value, enable)
//   i_ip_data/len/last/valid  IP payload byte stream, UDP header first;
//                             i_ip_len is held for the whole frame
//   o_udp_data/valid/last     delivered UDP payload bytes
//   o_udp_len                 UDP length field minus 8
//   o_udp_ch                  index of the matched table entry
//   o_udp_src_port            source port of the current datagram
//   o_err_short, o_err_len    one-cycle error pulses
//   o_drop_cnt                saturating count of dropped datagrams
module udp_rx_mux #(
  parameter int          P_PORT_NUM  = 4,
  parameter logic [15:0] P_PORT_BASE = 16'h8080,
  parameter int          CH_W        = (P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cfg_we,
  input  logic [2:0]      i_cfg_idx,
  input  logic [15:0]     i_cfg_port,
  input  logic            i_cfg_en,
  input  logic [7:0]      i_ip_data,
  input  logic [15:0]     i_ip_len,
  input  logic            i_ip_last,
  input  logic            i_ip_valid,
  output logic [7:0]      o_udp_data,
  output logic [15:0]     o_udp_len,
  output logic [CH_W-1:0] o_udp_ch,
  output logic [15:0]     o_udp_src_port,
  output logic            o_udp_last,
  output logic            o_udp_valid,
  output logic            o_err_short,
  output logic            o_err_len,
  output logic [15:0]     o_drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISCARD} state_t;

  state_t                state, state_nxt;
  logic [15:0]           cnt;       // index of the next valid byte (outside IDLE)
  logic [15:0]           idx;       // index of the byte currently presented
  logic [15:0]           src_q;
  logic [7:0]            dst_hi;
  logic [7:0]            len_hi;
  logic [15:0]           len_q;
  logic                  match_q;
  logic [15:0]           port_tbl [P_PORT_NUM];
  logic [P_PORT_NUM-1:0] en_tbl;

  logic                  hit;
  logic [CH_W-1:0]       hit_ch;
  logic [15:0]           len_w;
  logic                  len_bad;
  logic                  emit, emit_last, err_short_s, err_len_s, drop_s;

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int k = P_PORT_NUM - 1; k >= 0; k--) begin
      if (en_tbl[k] && (port_tbl[k] == {dst_hi, i_ip_data})) begin
        hit    = 1'b1;
        hit_ch = CH_W'(k);
      end
    end
  end

  always_comb begin
    idx         = (state == IDLE) ? 16'd0 : cnt;
    len_w       = {len_hi, i_ip_data};
    len_bad     = (len_w < 16'd8) || (len_w > i_ip_len);
    state_nxt   = state;
    emit        = 1'b0;
    emit_last   = 1'b0;
    err_short_s = 1'b0;
    err_len_s   = 1'b0;
    drop_s      = 1'b0;
    if (i_ip_valid) begin
      case (state)
        IDLE, HDR: begin
          state_nxt = HDR;
          if ((idx == 16'd5) && len_bad) begin
            // A bad length drops the datagram on its own; no short error is added later.
            err_len_s = 1'b1;
            drop_s    = 1'b1;
            state_nxt = DISCARD;
          end else if (idx == 16'd7) begin
            if (!match_q) begin
              drop_s    = 1'b1;
              state_nxt = DISCARD;
            end else if (i_ip_last && (len_q != 16'd8)) begin
              // The header is complete but the payload is missing.
              err_short_s = 1'b1;
              drop_s      = 1'b1;
            end else begin
              state_nxt = PAYLOAD;
            end
          end else if (i_ip_last) begin
            err_short_s = 1'b1;
            drop_s      = 1'b1;
          end
        end
        PAYLOAD: begin
          if (idx < len_q) begin
            emit = 1'b1;
            if (idx == len_q - 16'd1) begin
              emit_last = 1'b1;
              state_nxt = DISCARD;
            end else if (i_ip_last) begin
              emit_last   = 1'b1;
              err_short_s = 1'b1;
            end
          end else begin
            state_nxt = DISCARD;
          end
        end
        default: ;
      endcase
      if (i_ip_last) state_nxt = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      cnt            <= 16'd0;
      src_q          <= 16'd0;
      dst_hi         <= 8'd0;
      len_hi         <= 8'd0;
      len_q          <= 16'd0;
      match_q        <= 1'b0;
      o_udp_data     <= 8'd0;
      o_udp_len      <= 16'd0;
      o_udp_ch       <= '0;
      o_udp_src_port <= 16'd0;
      o_udp_last     <= 1'b0;
      o_udp_valid    <= 1'b0;
      o_err_short    <= 1'b0;
      o_err_len      <= 1'b0;
      o_drop_cnt     <= 16'd0;
      en_tbl         <= '1;
      for (int k = 0; k < P_PORT_NUM; k++) port_tbl[k] <= P_PORT_BASE + 16'(k);
    end else begin
      state       <= state_nxt;
      o_udp_valid <= emit;
      o_udp_last  <= emit_last;
      o_err_short <= err_short_s;
      o_err_len   <= err_len_s;
      if (emit) o_udp_data <= i_ip_data;
      if (drop_s && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;

      if (i_ip_valid) begin
        cnt <= (idx == 16'hFFFF) ? idx : idx + 16'd1;
        case (idx)
          16'd0: src_q[15:8] <= i_ip_data;
          16'd1: src_q[7:0]  <= i_ip_data;
          16'd2: dst_hi      <= i_ip_data;
          16'd3: begin
            match_q <= hit;
            if (hit) o_udp_ch <= hit_ch;
          end
          16'd4: len_hi <= i_ip_data;
          16'd5: begin
            len_q          <= len_w;
            o_udp_len      <= len_w - 16'd8;
            o_udp_src_port <= src_q;
          end
          default: ;
        endcase
      end

      for (int k = 0; k < P_PORT_NUM; k++) begin
        if (i_cfg_we && (i_cfg_idx == 3'(k))) begin
          port_tbl[k] <= i_cfg_port;
          en_tbl[k]   <= i_cfg_en;
        end
      end
    end
  end

endmodule

// File: doc/udp_rx_mux.md
UDP_RX_MUX -- requirements
Module: udp_rx_mux

Interface
REQ-001 SHALL have parameters: P_PORT_NUM, default 4, number of listening port entries (1..8); P_PORT_BASE, default 16'h8080, reset value of entry k = P_PORT_BASE + k; CH_W, default 2, channel index width = max(1, clog2(P_PORT_NUM)).
REQ-002 SHALL have ports (name direction width meaning):
 i_clk  in  1  single clock, all logic on rising edge.
 i_rst  in  1  synchronous active-high reset.
 i_cfg_we  in  1  port table write strobe.
 i_cfg_idx  in  3  entry index to write.
 i_cfg_port  in  16  port value to write.
 i_cfg_en  in  1  entry enable to write.
 i_ip_data  in  8  IP payload byte (UDP header first).
 i_ip_len  in  16  IP payload length in bytes, stable for the whole frame.
 i_ip_last  in  1  final byte of IP payload.
 i_ip_valid  in  1  byte qualifier; gaps allowed mid-frame.
 o_udp_data  out  8  UDP payload byte.
 o_udp_len  out  16  UDP payload length (UDP length field - 8).
 o_udp_ch  out  CH_W  matched entry index.
 o_udp_src_port  out  16  source port of current datagram.
 o_udp_last  out  1  final delivered payload byte.
 o_udp_valid  out  1  payload byte qualifier.
 o_err_short  out  1  one-cycle pulse, frame ended early.
 o_err_len  out  1  one-cycle pulse, bad UDP length field.
 o_drop_cnt  out  16  saturating dropped-datagram count.

Function
REQ-003 SHALL count only bytes with i_ip_valid=1; byte index n=0 at first valid byte after IDLE.
REQ-004 SHALL use states IDLE, HDR, PAYLOAD, DISCARD; IDLE->HDR on valid byte 0; HDR->PAYLOAD after byte 7 if accepted; any state->IDLE after a valid byte with i_ip_last=1.
REQ-005 SHALL capture src port from bytes 0-1, dst port from bytes 2-3, length L from bytes 4-5, big-endian; bytes 6-7 (checksum) ignored.
REQ-006 SHALL compare dst port against all enabled entries when byte 3 is accepted; lowest matching index wins and is latched into o_udp_ch.
REQ-007 SHALL drop (enter DISCARD after byte 7) when no entry matches.
REQ-008 SHALL flag L<8 or L>i_ip_len: o_err_len pulse the cycle after byte 5, datagram dropped.
REQ-009 SHALL register o_udp_len=L-8 and o_udp_src_port the cycle after byte 5; held until next frame's byte 5.
REQ-010 SHALL output payload byte n (n>=8) on o_udp_data with o_udp_valid=1 exactly one cycle after acceptance; o_udp_valid=0 otherwise.
REQ-011 SHALL assert o_udp_last with byte n=L-1; bytes n>=L (IP padding) discarded without error.
REQ-012 SHALL, when i_ip_last arrives in PAYLOAD before n=L-1, assert o_udp_last with that byte and pulse o_err_short in the same cycle.
REQ-013 SHALL, when i_ip_last arrives in HDR, pulse o_err_short one cycle later, emit no payload, count a drop.
REQ-014 SHALL deliver nothing for L=8 (no valid, no last, no error).
REQ-015 SHALL increment o_drop_cnt once per datagram dropped by REQ-007, REQ-008 or REQ-013; saturate at 16'hFFFF; truncated deliveries (REQ-012) not counted.
REQ-016 SHALL apply a config write the next cycle; i_cfg_idx>=P_PORT_NUM ignored; writes mid-frame affect only comparisons after the write.

Reset
REQ-017 SHALL on i_rst=1 force state IDLE, byte count 0, all outputs 0, o_drop_cnt 0, entry k = P_PORT_BASE+k enabled.
REQ-018 SHALL treat the first valid byte after reset release as byte 0.

Verification
REQ-019 Frame dst=8081, L=12, ip_len=12, payload AA BB CC DD -> o_udp_ch=1, o_udp_len=4, four valid bytes, last with DD, no errors.
REQ-020 Same frame, dst=9000 -> no o_udp_valid, o_drop_cnt 0->1.
REQ-021 L=6 -> o_err_len pulse, drop count +1; L=10, ip_len=14 -> 2 bytes delivered, padding discarded, no error.
REQ-022 L=20, i_ip_last at byte 11 -> 4 bytes, last+o_err_short on byte 11; i_ip_last at byte 4 -> o_err_short, drop +1.
REQ-023 Write idx 0 port 1234, en 1 plus idx 2 port 1234 -> dst=1234 matches ch 0; disable idx 0 -> ch 2; i_ip_valid gaps mid-frame -> identical output data.
REQ-024 Assert i_rst mid-payload -> all outputs 0 next cycle, following frame parsed correctly.
